// File: rtl/fp_issue_scheduler_pkg.sv
// Shared types for FP issue scheduling: FP stage names, pipeline depth and
// the occupancy entry carried down fx1..fx5.
package fp_issue_scheduler_pkg;

  localparam int NUM_HW_THREADS  = 4;
  localparam int THREAD_IDX_W    = $clog2(NUM_HW_THREADS);
  localparam int FP_MAX_INFLIGHT = 3;

  typedef logic [THREAD_IDX_W-1:0] local_thread_idx_t;

  typedef enum logic [2:0] {
    FX1 = 3'd0,
    FX2 = 3'd1,
    FX3 = 3'd2,
    FX4 = 3'd3,
    FX5 = 3'd4
  } fp_stage_t;

  localparam int FP_LATENCY = int'(FX5) + 1;

  typedef struct packed {
    logic              valid;
    local_thread_idx_t thread;
  } fp_sched_entry_t;

endpackage

// File: rtl/fp_issue_scheduler_rr_arbiter.sv
// Generic one-hot round-robin arbiter; the pointer moves past the winner
// only when update_lru is set and something was granted.
module rr_arbiter #(
  parameter  int NUM_REQUESTERS = 4,
  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant,
  output logic [IW-1:0]             grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQUESTERS;
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (update_lru && found)
      ptr_d = IW'((int'(grant_idx) + 1) % NUM_REQUESTERS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp_issue_scheduler.sv
// FP issue scheduler: round-robin grant among threads, per-thread in-flight
// limit, and a fixed-latency occupancy shadow of fx1..fx5 with rollback squash.
module fp_issue_scheduler #(
  parameter  int NUM_THREADS  = fp_issue_scheduler_pkg::NUM_HW_THREADS,
  parameter  int FP_LATENCY   = fp_issue_scheduler_pkg::FP_LATENCY,
  parameter  int MAX_INFLIGHT = fp_issue_scheduler_pkg::FP_MAX_INFLIGHT,
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] fp_req,
  input  logic                   issue_block,
  input  logic                   rollback_en,
  input  logic [TW-1:0]          rollback_thread,
  output logic [NUM_THREADS-1:0] fp_grant,
  output logic [NUM_THREADS-1:0] thread_fp_full,
  output logic                   fx_issue_valid,
  output logic [TW-1:0]          fx_issue_thread,
  output logic                   wb_valid,
  output logic [TW-1:0]          wb_thread,
  output logic                   pipe_empty
);
  import fp_issue_scheduler_pkg::*;

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  fp_sched_entry_t [FP_LATENCY-1:0]   pipe_q, pipe_d;
  logic [NUM_THREADS-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [NUM_THREADS-1:0]             full_q, full_d;
  logic [NUM_THREADS-1:0]             eligible;
  logic [TW-1:0]                      grant_idx;
  int                                 cnt_nxt [NUM_THREADS];

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++)
      eligible[t] = fp_req[t] & ~full_q[t] & ~issue_block &
                    ~(rollback_en && rollback_thread == TW'(t));
  end

  rr_arbiter #(.NUM_REQUESTERS(NUM_THREADS)) u_rr_arbiter (
    .clk        (clk),
    .rst_n      (reset),
    .request    (eligible),
    .update_lru (1'b1),
    .grant      (fp_grant),
    .grant_idx  (grant_idx)
  );

  // The retiring slot is never squashed: its writeback is already committed.
  always_comb begin
    pipe_d[0].valid  = |fp_grant;
    pipe_d[0].thread = local_thread_idx_t'(grant_idx);
    for (int i = 1; i < FP_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
      if (rollback_en && TW'(pipe_q[i-1].thread) == rollback_thread)
        pipe_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      cnt_nxt[t] = int'(cnt_q[t]);
      if (fp_grant[t])
        cnt_nxt[t] = cnt_nxt[t] + 1;
      if (wb_valid && wb_thread == TW'(t))
        cnt_nxt[t] = cnt_nxt[t] - 1;
      if (rollback_en && rollback_thread == TW'(t)) begin
        for (int i = 0; i < FP_LATENCY - 1; i++)
          if (pipe_q[i].valid && TW'(pipe_q[i].thread) == TW'(t))
            cnt_nxt[t] = cnt_nxt[t] - 1;
      end
      cnt_d[t]  = CW'(cnt_nxt[t]);
      full_d[t] = (cnt_nxt[t] == MAX_INFLIGHT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
      cnt_q  <= '0;
      full_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      for (int t = 0; t < NUM_THREADS; t++)
        assert (cnt_nxt[t] >= 0 && cnt_nxt[t] <= MAX_INFLIGHT);
    end
  end

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < FP_LATENCY; i++)
      if (pipe_q[i].valid) pipe_empty = 1'b0;
  end

  assign thread_fp_full  = full_q;
  assign fx_issue_valid  = pipe_q[0].valid;
  assign fx_issue_thread = TW'(pipe_q[0].thread);
  assign wb_valid        = pipe_q[FP_LATENCY-1].valid;
  assign wb_thread       = TW'(pipe_q[FP_LATENCY-1].thread);

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Bench for fp_issue_scheduler: op-list scoreboard checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_fp_issue_scheduler;

  localparam int NT   = 4;
  localparam int L    = 5;
  localparam int MAXI = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NT-1:0] fp_req = '0;
  logic          issue_block = 1'b0;
  logic          rollback_en = 1'b0;
  logic [1:0]    rollback_thread = '0;
  logic [NT-1:0] fp_grant, thread_fp_full;
  logic          fx_issue_valid, wb_valid, pipe_empty;
  logic [1:0]    fx_issue_thread, wb_thread;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fp_issue_scheduler #(.NUM_THREADS(NT), .FP_LATENCY(L), .MAX_INFLIGHT(MAXI)) dut (
    .clk             (clk),
    .reset           (reset),
    .fp_req          (fp_req),
    .issue_block     (issue_block),
    .rollback_en     (rollback_en),
    .rollback_thread (rollback_thread),
    .fp_grant        (fp_grant),
    .thread_fp_full  (thread_fp_full),
    .fx_issue_valid  (fx_issue_valid),
    .fx_issue_thread (fx_issue_thread),
    .wb_valid        (wb_valid),
    .wb_thread       (wb_thread),
    .pipe_empty      (pipe_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: every granted op with its grant cycle and (if squashed) the
  // rollback cycle. An op occupies the pipe in cycles g+1..g+L.
  typedef struct { int thr; int g; int r; } op_t;
  op_t ops[$];
  int  rr_m = 0;

  function automatic bit alive(input op_t o, input int c);
    return (o.g < c) && (c <= o.g + L) && !(o.r >= 0 && c > o.r);
  endfunction

  int            cnt [NT];
  int            tot, gsel, idx, e_fxt, e_wbt;
  logic          e_fxv, e_wbv;
  logic [NT-1:0] e_full, e_gnt;

  always @(negedge clk) begin : cmp
    if (!reset) begin
      ops.delete();
      rr_m = 0;
      chk("rst_grant",   32'(fp_grant), 32'd0);
      chk("rst_full",    32'(thread_fp_full), 32'd0);
      chk("rst_fxv",     32'(fx_issue_valid), 32'd0);
      chk("rst_fxt",     32'(fx_issue_thread), 32'd0);
      chk("rst_wbv",     32'(wb_valid), 32'd0);
      chk("rst_wbt",     32'(wb_thread), 32'd0);
      chk("rst_empty",   32'(pipe_empty), 32'd1);
    end else begin
      tot = 0; e_fxv = 1'b0; e_fxt = 0; e_wbv = 1'b0; e_wbt = 0;
      for (int t = 0; t < NT; t++) cnt[t] = 0;
      foreach (ops[i]) begin
        if (alive(ops[i], cyc)) begin cnt[ops[i].thr]++; tot++; end
        if (ops[i].g == cyc - 1) begin e_fxv = 1'b1; e_fxt = ops[i].thr; end
        if (ops[i].g == cyc - L && alive(ops[i], cyc)) begin e_wbv = 1'b1; e_wbt = ops[i].thr; end
      end
      for (int t = 0; t < NT; t++) e_full[t] = (cnt[t] == MAXI);
      gsel = -1; e_gnt = '0;
      for (int i = 0; i < NT; i++) begin
        idx = (rr_m + i) % NT;
        if (gsel < 0 && fp_req[idx] && !e_full[idx] && !issue_block &&
            !(rollback_en && int'(rollback_thread) == idx))
          gsel = idx;
      end
      if (gsel >= 0) e_gnt[gsel] = 1'b1;
      chk("m_grant", 32'(fp_grant), 32'(e_gnt));
      chk("m_full",  32'(thread_fp_full), 32'(e_full));
      chk("m_fxv",   32'(fx_issue_valid), 32'(e_fxv));
      if (e_fxv) chk("m_fxt", 32'(fx_issue_thread), 32'(e_fxt));
      chk("m_wbv",   32'(wb_valid), 32'(e_wbv));
      if (e_wbv) chk("m_wbt", 32'(wb_thread), 32'(e_wbt));
      chk("m_empty", 32'(pipe_empty), 32'(tot == 0));
      if (rollback_en) begin
        foreach (ops[i])
          if (ops[i].thr == int'(rollback_thread) && ops[i].r < 0 &&
              ops[i].g + 1 <= cyc && cyc <= ops[i].g + L - 1)
            ops[i].r = cyc;
      end
      if (gsel >= 0) begin
        ops.push_back('{thr: gsel, g: cyc, r: -1});
        rr_m = (gsel + 1) % NT;
      end
      while (ops.size() > 0 && ops[0].g + L < cyc) void'(ops.pop_front());
    end
    cyc++;
  end

  task automatic set_in(input logic [NT-1:0] req, input logic blk, input logic rb, input logic [1:0] rbt);
    fp_req = req; issue_block = blk; rollback_en = rb; rollback_thread = rbt;
  endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask
  task automatic drain(input int n);
    set_in('0, 1'b0, 1'b0, 2'd0);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // A: all threads request; 0,1,2,3,0,... and writeback L cycles after grant
    for (int k = 0; k < 8; k++) begin
      set_in(4'b1111, 1'b0, 1'b0, 2'd0); mid();
      if (k < 4) chk("A_grant", 32'(fp_grant), 32'(1) << k);
      if (k == 1) begin chk("A_fxv", 32'(fx_issue_valid), 32'd1); chk("A_fxt", 32'(fx_issue_thread), 32'd0); end
      if (k == 4) chk("A_wb_early", 32'(wb_valid), 32'd0);
      if (k == 5) begin chk("A_wb_first", 32'(wb_valid), 32'd1); chk("A_wb_thr", 32'(wb_thread), 32'd0); end
      tick();
    end
    drain(8); mid(); chk("A_drained", 32'(pipe_empty), 32'd1); tick();

    // B: single thread fills to MAX_INFLIGHT, resumes after first retire
    for (int k = 0; k < 12; k++) begin
      set_in(4'b0001, 1'b0, 1'b0, 2'd0); mid();
      if (k <= 2) chk("B_grant", 32'(fp_grant), 32'd1);
      if (k == 2) chk("B_notfull", 32'(thread_fp_full[0]), 32'd0);
      if (k == 3) begin chk("B_full", 32'(thread_fp_full[0]), 32'd1); chk("B_nogrant", 32'(fp_grant), 32'd0); end
      if (k == 5) begin chk("B_wb", 32'(wb_valid), 32'd1); chk("B_stall", 32'(fp_grant), 32'd0); end
      if (k == 6) chk("B_resume", 32'(fp_grant), 32'd1);
      tick();
    end
    drain(8);

    // C: thread 2 ops in fx4 and fx2 squashed by rollback
    for (int k = 0; k < 9; k++) begin
      case (k)
        0, 2:    set_in(4'b0100, 1'b0, 1'b0, 2'd0);
        4:       set_in(4'b0100, 1'b0, 1'b1, 2'd2);
        5, 6, 7: set_in(4'b0100, 1'b0, 1'b0, 2'd0);
        default: set_in(4'b0000, 1'b0, 1'b0, 2'd0);
      endcase
      mid();
      if (k == 4) chk("C_rb_nogrant", 32'(fp_grant), 32'd0);
      if (k == 5) begin chk("C_empty", 32'(pipe_empty), 32'd1); chk("C_wb5", 32'(wb_valid), 32'd0); end
      if (k == 7) chk("C_wb7", 32'(wb_valid), 32'd0);
      if (k == 8) chk("C_refull", 32'(thread_fp_full[2]), 32'd1);
      tick();
    end
    drain(8);

    // D: rollback thread 1 while its oldest op is in fx5
    for (int k = 0; k < 11; k++) begin
      case (k)
        0, 1, 7, 8, 9: set_in(4'b0010, 1'b0, 1'b0, 2'd0);
        5:             set_in(4'b0000, 1'b0, 1'b1, 2'd1);
        default:       set_in(4'b0000, 1'b0, 1'b0, 2'd0);
      endcase
      mid();
      if (k == 5) begin chk("D_wb", 32'(wb_valid), 32'd1); chk("D_wbt", 32'(wb_thread), 32'd1); end
      if (k == 6) begin chk("D_sq", 32'(wb_valid), 32'd0); chk("D_empty", 32'(pipe_empty), 32'd1); end
      if (k == 10) chk("D_refull", 32'(thread_fp_full[1]), 32'd1);
      tick();
    end
    drain(8);

    // E: issue_block holds grants and the pointer
    for (int k = 0; k < 6; k++) begin
      if (k == 0)     set_in(4'b0001, 1'b0, 1'b0, 2'd0);
      else if (k < 4) set_in(4'b1010, 1'b1, 1'b0, 2'd0);
      else            set_in(4'b1010, 1'b0, 1'b0, 2'd0);
      mid();
      if (k >= 1 && k <= 3) chk("E_block", 32'(fp_grant), 32'd0);
      if (k == 4) chk("E_rel1", 32'(fp_grant), 32'b0010);
      if (k == 5) chk("E_rel3", 32'(fp_grant), 32'b1000);
      tick();
    end
    drain(8);

    // F: asynchronous reset with five ops in flight
    for (int k = 0; k < 5; k++) begin set_in(4'b1111, 1'b0, 1'b0, 2'd0); tick(); end
    set_in('0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    #1;
    chk("F_wbv",   32'(wb_valid), 32'd0);
    chk("F_fxv",   32'(fx_issue_valid), 32'd0);
    chk("F_empty", 32'(pipe_empty), 32'd1);
    chk("F_full",  32'(thread_fp_full), 32'd0);
    tick(); tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin mid(); chk("F_no_wb", 32'(wb_valid), 32'd0); tick(); end

    // G: mixed pseudo-random traffic against the scoreboard
    for (int k = 0; k < 80; k++) begin
      set_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)));
      tick();
    end
    drain(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
